// File: rtl/operand_b_stage_pkg.sv
// Shared CPU constants for the operand-B path: immediate extension encodings
// and the forwarding-hit rule used by the E stage.
package operand_b_stage_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO     = 2'b00,
    EXT_SIGN     = 2'b01,
    EXT_UPPER    = 2'b10,
    EXT_ZERO_ALT = 2'b11
  } ext_op_e;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned IMM_W      = 16;

  // Register 0 is hardwired to zero, so it must never pick up a forwarded value.
  function automatic logic fwd_hit(input logic                  we,
                                   input logic [REG_ADDR_W-1:0] addr,
                                   input logic [REG_ADDR_W-1:0] rt);
    return we && (addr == rt) && (rt != '0);
  endfunction

endpackage

// File: rtl/operand_b_stage_imm_ext.sv
// Combinational 16-bit immediate extender: zero, sign or upper (imm << 16).
module imm_ext
  import operand_b_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [IMM_W-1:0] imm_i,
  input  logic [1:0]       ext_op_i,
  output logic [WIDTH-1:0] ext_o
);

  always_comb begin
    ext_o = '0;
    case (ext_op_e'(ext_op_i))
      EXT_SIGN:  ext_o = {{(WIDTH-IMM_W){imm_i[IMM_W-1]}}, imm_i};
      // Upper mode fills bits [31:16] only; anything above bit 31 stays zero.
      EXT_UPPER: ext_o[31:16] = imm_i;
      default:   ext_o = {{(WIDTH-IMM_W){1'b0}}, imm_i};
    endcase
  end

endmodule

// File: rtl/operand_b_stage.sv
// E-stage operand B: registers rt/rd2/extended immediate/select from D and
// applies M/W forwarding to the rt value before the ALU-B select.
module operand_b_stage
  import operand_b_stage_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      D_RD2,
  input  logic [IMM_W-1:0]      D_imm16,
  input  logic [1:0]            D_ext_op,
  input  logic                  D_sel,
  input  logic [REG_ADDR_W-1:0] D_rt,
  input  logic                  E_stall,
  input  logic                  E_flush,
  input  logic                  M_we,
  input  logic                  W_we,
  input  logic [REG_ADDR_W-1:0] M_addr,
  input  logic [REG_ADDR_W-1:0] W_addr,
  input  logic [WIDTH-1:0]      M_data,
  input  logic [WIDTH-1:0]      W_data,
  output logic [WIDTH-1:0]      ALU_B,
  output logic [WIDTH-1:0]      E_rt_data,
  output logic                  E_sel
);

  logic [REG_ADDR_W-1:0] rt_q, rt_d;
  logic [WIDTH-1:0]      rd2_q, rd2_d;
  logic [WIDTH-1:0]      ext_q, ext_d;
  logic                  sel_q, sel_d;
  logic [WIDTH-1:0]      D_ext;

  imm_ext #(.WIDTH(WIDTH)) u_imm_ext (
    .imm_i    (D_imm16),
    .ext_op_i (D_ext_op),
    .ext_o    (D_ext)
  );

  generate
    if (FWD_EN) begin : g_fwd
      always_comb begin
        E_rt_data = rd2_q;
        if (fwd_hit(M_we, M_addr, rt_q)) begin
          E_rt_data = M_data;
        end else if (fwd_hit(W_we, W_addr, rt_q)) begin
          E_rt_data = W_data;
        end
      end
    end else begin : g_no_fwd
      assign E_rt_data = rd2_q;
    end
  endgenerate

  assign ALU_B = sel_q ? ext_q : E_rt_data;
  assign E_sel = sel_q;

  // A stall re-captures the forwarded rt value so it outlives the producer's
  // retirement from W while the E stage is frozen.
  always_comb begin
    rt_d  = rt_q;
    rd2_d = rd2_q;
    ext_d = ext_q;
    sel_d = sel_q;
    if (E_flush) begin
      rt_d  = '0;
      rd2_d = '0;
      ext_d = '0;
      sel_d = 1'b0;
    end else if (E_stall) begin
      rd2_d = E_rt_data;
    end else begin
      rt_d  = D_rt;
      rd2_d = D_RD2;
      ext_d = D_ext;
      sel_d = D_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rt_q  <= '0;
      rd2_q <= '0;
      ext_q <= '0;
      sel_q <= 1'b0;
    end else begin
      rt_q  <= rt_d;
      rd2_q <= rd2_d;
      ext_q <= ext_d;
      sel_q <= sel_d;
    end
  end

endmodule

// File: tb/tb_operand_b_stage.sv
// Self-checking bench for operand_b_stage: table of single-load vectors plus
// hand-written stall/flush/reset sequences, checked through a scoreboard queue.
module tb_operand_b_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] D_RD2;
  logic [15:0] D_imm16;
  logic [1:0]  D_ext_op;
  logic        D_sel;
  logic [4:0]  D_rt;
  logic        E_stall, E_flush;
  logic        M_we, W_we;
  logic [4:0]  M_addr, W_addr;
  logic [31:0] M_data, W_data;
  logic [31:0] ALU_B, E_rt_data;
  logic        E_sel;

  operand_b_stage #(.WIDTH(32), .FWD_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .D_RD2     (D_RD2),
    .D_imm16   (D_imm16),
    .D_ext_op  (D_ext_op),
    .D_sel     (D_sel),
    .D_rt      (D_rt),
    .E_stall   (E_stall),
    .E_flush   (E_flush),
    .M_we      (M_we),
    .W_we      (W_we),
    .M_addr    (M_addr),
    .W_addr    (W_addr),
    .M_data    (M_data),
    .W_data    (W_data),
    .ALU_B     (ALU_B),
    .E_rt_data (E_rt_data),
    .E_sel     (E_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] aluB;
    logic [31:0] rtData;
    logic        sel;
  } expT;

  typedef struct {
    string       name;
    logic [4:0]  rt;
    logic [31:0] rd2;
    logic [15:0] imm;
    logic [1:0]  op;
    logic        sel;
    logic        mWe;
    logic [4:0]  mAddr;
    logic [31:0] mData;
    logic        wWe;
    logic [4:0]  wAddr;
    logic [31:0] wData;
    logic [31:0] expAluB;
    logic [31:0] expRtData;
    logic        expSel;
  } vecT;

  expT sbQ[$];
  vecT vecs[$];
  int  testsRun    = 0;
  int  testsFailed = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] rt, input logic [31:0] rd2,
                               input logic [15:0] imm, input logic [1:0] op,
                               input logic sel, input logic stall, input logic flush);
    D_rt     = rt;
    D_RD2    = rd2;
    D_imm16  = imm;
    D_ext_op = op;
    D_sel    = sel;
    E_stall  = stall;
    E_flush  = flush;
  endtask

  task automatic setFwd(input logic mWe, input logic [4:0] mAddr, input logic [31:0] mData,
                        input logic wWe, input logic [4:0] wAddr, input logic [31:0] wData);
    M_we   = mWe;
    M_addr = mAddr;
    M_data = mData;
    W_we   = wWe;
    W_addr = wAddr;
    W_data = wData;
  endtask

  task automatic pushExp(input string name, input logic [31:0] aluB,
                         input logic [31:0] rtData, input logic sel);
    expT e;
    e.name   = name;
    e.aluB   = aluB;
    e.rtData = rtData;
    e.sel    = sel;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput();
    expT e;
    testsRun++;
    if (sbQ.size() == 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_empty: no expected entry, got ALU_B=%h", ALU_B);
    end else begin
      e = sbQ.pop_front();
      if (ALU_B !== e.aluB || E_rt_data !== e.rtData || E_sel !== e.sel) begin
        testsFailed++;
        $display("[TB] FAIL %s: got ALU_B=%h E_rt_data=%h E_sel=%b, required ALU_B=%h E_rt_data=%h E_sel=%b",
                 e.name, ALU_B, E_rt_data, E_sel, e.aluB, e.rtData, e.sel);
      end
    end
  endtask

  task automatic addVec(input string name, input logic [4:0] rt, input logic [31:0] rd2,
                        input logic [15:0] imm, input logic [1:0] op, input logic sel,
                        input logic mWe, input logic [4:0] mAddr, input logic [31:0] mData,
                        input logic wWe, input logic [4:0] wAddr, input logic [31:0] wData,
                        input logic [31:0] expAluB, input logic [31:0] expRtData, input logic expSel);
    vecT v;
    v.name = name; v.rt = rt; v.rd2 = rd2; v.imm = imm; v.op = op; v.sel = sel;
    v.mWe = mWe; v.mAddr = mAddr; v.mData = mData;
    v.wWe = wWe; v.wAddr = wAddr; v.wData = wData;
    v.expAluB = expAluB; v.expRtData = expRtData; v.expSel = expSel;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got none, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    addVec("sign_8000",   5'd7, 32'h11, 16'h8000, 2'b01, 1'b1, 0, 0, 0,      0, 0, 0,      32'hFFFF8000, 32'h11, 1'b1);
    addVec("zero_8000",   5'd7, 32'h11, 16'h8000, 2'b00, 1'b1, 0, 0, 0,      0, 0, 0,      32'h00008000, 32'h11, 1'b1);
    addVec("upper_8000",  5'd7, 32'h11, 16'h8000, 2'b10, 1'b1, 0, 0, 0,      0, 0, 0,      32'h80000000, 32'h11, 1'b1);
    addVec("zero11_8000", 5'd7, 32'h11, 16'h8000, 2'b11, 1'b1, 0, 0, 0,      0, 0, 0,      32'h00008000, 32'h11, 1'b1);
    addVec("sign_7fff",   5'd7, 32'h11, 16'h7FFF, 2'b01, 1'b1, 0, 0, 0,      0, 0, 0,      32'h00007FFF, 32'h11, 1'b1);
    addVec("fwd_m_prio",  5'd5, 32'h1,  16'h0,    2'b00, 1'b0, 1, 5, 32'hAA, 1, 5, 32'hBB, 32'hAA, 32'hAA, 1'b0);
    addVec("fwd_w",       5'd5, 32'h1,  16'h0,    2'b00, 1'b0, 0, 5, 32'hAA, 1, 5, 32'hBB, 32'hBB, 32'hBB, 1'b0);
    addVec("fwd_miss",    5'd5, 32'h1,  16'h0,    2'b00, 1'b0, 1, 6, 32'hAA, 1, 4, 32'hBB, 32'h1,  32'h1,  1'b0);
    addVec("fwd_r0_m",    5'd0, 32'h0,  16'h0,    2'b00, 1'b0, 1, 0, 32'h55, 0, 0, 0,      32'h0,  32'h0,  1'b0);
    addVec("fwd_r0_w",    5'd0, 32'h77, 16'h0,    2'b00, 1'b0, 0, 0, 0,      1, 0, 32'h66, 32'h77, 32'h77, 1'b0);
    addVec("fwd_we_off",  5'd9, 32'h42, 16'h0,    2'b00, 1'b0, 0, 9, 32'hAA, 0, 9, 32'hBB, 32'h42, 32'h42, 1'b0);
    addVec("sel_imm_fwd", 5'd5, 32'h1,  16'h1234, 2'b10, 1'b1, 1, 5, 32'hCC, 0, 0, 0,      32'h12340000, 32'hCC, 1'b1);

    // Reset must win over a pending load of non-zero D values.
    reset = 1'b0;
    setFwd(0, 0, 0, 0, 0, 0);
    applyStimulus(5'd3, 32'hDEADBEEF, 16'hFFFF, 2'b01, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    pushExp("reset_state", 32'h0, 32'h0, 1'b0);
    checkOutput();
    reset = 1'b1;

    foreach (vecs[i]) begin
      setFwd(vecs[i].mWe, vecs[i].mAddr, vecs[i].mData, vecs[i].wWe, vecs[i].wAddr, vecs[i].wData);
      applyStimulus(vecs[i].rt, vecs[i].rd2, vecs[i].imm, vecs[i].op, vecs[i].sel, 1'b0, 1'b0);
      pushExp(vecs[i].name, vecs[i].expAluB, vecs[i].expRtData, vecs[i].expSel);
      tick();
      checkOutput();
    end

    // Forwarded W value must survive W retirement while the stage is stalled.
    setFwd(0, 0, 0, 0, 0, 0);
    applyStimulus(5'd3, 32'h9, 16'h1111, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    pushExp("stall_load", 32'h9, 32'h9, 1'b0);
    checkOutput();
    setFwd(0, 0, 0, 1, 3, 32'h1234);
    applyStimulus(5'd4, 32'hDEAD, 16'hFFFF, 2'b01, 1'b1, 1'b1, 1'b0);
    #1;
    pushExp("stall_fwd_comb", 32'h1234, 32'h1234, 1'b0);
    checkOutput();
    tick();
    setFwd(0, 0, 0, 0, 0, 0);
    #1;
    pushExp("stall_hold_1", 32'h1234, 32'h1234, 1'b0);
    checkOutput();
    tick();
    pushExp("stall_hold_2", 32'h1234, 32'h1234, 1'b0);
    checkOutput();
    tick();
    pushExp("stall_hold_3", 32'h1234, 32'h1234, 1'b0);
    checkOutput();

    E_stall = 1'b0;
    tick();
    pushExp("load_after_stall", 32'hFFFFFFFF, 32'hDEAD, 1'b1);
    checkOutput();

    applyStimulus(5'd4, 32'hDEAD, 16'hFFFF, 2'b01, 1'b1, 1'b1, 1'b1);
    tick();
    pushExp("stall_and_flush", 32'h0, 32'h0, 1'b0);
    checkOutput();

    applyStimulus(5'd6, 32'h5678, 16'h8001, 2'b10, 1'b1, 1'b0, 1'b0);
    tick();
    pushExp("load_upper", 32'h80010000, 32'h5678, 1'b1);
    checkOutput();
    applyStimulus(5'd8, 32'h9999, 16'h0042, 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    pushExp("stall_holds_ext", 32'h80010000, 32'h5678, 1'b1);
    checkOutput();

    reset = 1'b0;
    tick();
    pushExp("reset_in_stall", 32'h0, 32'h0, 1'b0);
    checkOutput();
    reset = 1'b1;

    applyStimulus(5'd2, 32'hABCD, 16'h00FF, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    pushExp("load_before_flush", 32'hABCD, 32'hABCD, 1'b0);
    checkOutput();
    E_flush = 1'b1;
    tick();
    pushExp("flush_only", 32'h0, 32'h0, 1'b0);
    checkOutput();
    E_flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/operand_b_stage.md
OPERAND_B_STAGE -- requirements
Module: operand_b_stage

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; SHALL be >= 32.
REQ-002 Parameter FWD_EN, default 1, enables M/W forwarding; 0 = forwarding logic absent.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low; sampled on rising clk only.
REQ-005 D_RD2  input  WIDTH  GRF rt read data from D stage.
REQ-006 D_imm16  input  16  instruction immediate.
REQ-007 D_ext_op  input  2  00 zero-ext, 01 sign-ext, 10 upper (imm<<16), 11 zero-ext.
REQ-008 D_sel  input  1  operand B source: 0 register, 1 extended immediate.
REQ-009 D_rt  input  5  rt register number.
REQ-010 E_stall  input  1  hold E-stage contents.
REQ-011 E_flush  input  1  load bubble into E stage.
REQ-012 M_we, W_we  input  1  forwarding-source write enables.
REQ-013 M_addr, W_addr  input  5  forwarding-source destination registers.
REQ-014 M_data, W_data  input  WIDTH  forwarding-source values.
REQ-015 ALU_B  output  WIDTH  selected ALU operand B.
REQ-016 E_rt_data  output  WIDTH  forwarded rt value (store data), independent of select.
REQ-017 E_sel  output  1  registered D_sel.

Function
REQ-018 Registers SHALL be: rt_q (5), rd2_q (WIDTH), ext_q (WIDTH), sel_q (1).
REQ-019 Extension SHALL be computed from D inputs and registered into ext_q; latency 1 cycle D->E.
REQ-020 Upper mode SHALL place imm16 at bits [31:16], zeros elsewhere; sign mode SHALL replicate imm16[15] through bit WIDTH-1.
REQ-021 Forward hit SHALL require we=1, addr==rt_q, and rt_q!=0; M hit SHALL take priority over W hit.
REQ-022 E_rt_data SHALL be M_data on M hit, else W_data on W hit, else rd2_q (combinational from registers and forwarding inputs).
REQ-023 ALU_B SHALL equal ext_q when sel_q=1, else E_rt_data.
REQ-024 Update priority per edge SHALL be: reset, then flush, then stall, then load.
REQ-025 Load (no stall, no flush): rt_q<=D_rt, rd2_q<=D_RD2, ext_q<=extended imm, sel_q<=D_sel.
REQ-026 Stall (no flush): rt_q, ext_q, sel_q SHALL hold; rd2_q SHALL capture E_rt_data so a forwarded value survives W retirement.
REQ-027 Flush (with or without stall): all registers SHALL clear to 0.
REQ-028 With FWD_EN=0, E_rt_data SHALL equal rd2_q and stall SHALL purely hold.

Reset
REQ-029 While reset=0 at a rising edge all registers SHALL clear to 0; ALU_B, E_rt_data, E_sel SHALL read 0 the following cycle.
REQ-030 Reset asserted mid-stall SHALL discard held state; no asynchronous path from reset to any output.

Structure
REQ-031 ext_op encodings (EXT_ZERO, EXT_SIGN, EXT_UPPER) SHALL live in the shared CPU constants package.
REQ-032 Extension SHALL be a sub-module imm_ext (combinational, WIDTH-parametrised); forwarding mux and registers stay in operand_b_stage.

Verification
REQ-033 Load D_imm16=16'h8000, D_ext_op=01, D_sel=1 -> next cycle ALU_B=32'hFFFF8000; with ext_op=00 -> 32'h00008000; with ext_op=10 -> 32'h80000000.
REQ-034 rt_q=5, rd2_q=1, M_we=1 M_addr=5 M_data=32'hAA, W_we=1 W_addr=5 W_data=32'hBB, sel_q=0 -> ALU_B=32'hAA; drop M_we -> 32'hBB.
REQ-035 rt_q=0, M_we=1 M_addr=0 M_data=32'h55, rd2_q=0 -> ALU_B=0.
REQ-036 E_stall=1, rt_q=3, W_we=1 W_addr=3 W_data=32'h1234 for one cycle, then W_we=0, stall held 2 more cycles -> E_rt_data stays 32'h1234.
REQ-037 E_stall=1 and E_flush=1 on the same edge -> all outputs 0 next cycle; reset=0 during stall -> all outputs 0 next cycle.
